mod_exp_engine: RTL and testbench

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

---
 rtl/dh_pkg.sv | 27 ++
 rtl/mod_exp_engine_if.sv | 21 ++
 rtl/mod_reduce.sv | 68 ++++++
 rtl/mod_exp_engine.sv | 139 +++++++++++++
 tb/tb_mod_exp_engine.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dh_pkg.sv
// Shared definitions for the Diffie-Hellman modular exponentiation datapath:
// default operand width, exponentiation FSM states and the reducer cycle count.
package dh_pkg;

  localparam int DW_DEF = 32;

  // One quotient bit per cycle over a double-width dividend.
  localparam int RED_CYCLES = 2 * DW_DEF;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    RED_BASE,
    CHK_BIT,
    MUL_ACC,
    RED_ACC,
    SQR,
    RED_SQR,
    FINISH
  } state_t;

  // Reducer cycle count for an arbitrary operand width.
  function automatic int red_cycles(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/mod_exp_engine_if.sv
// Request/response bundle of the modular exponentiation engine.
interface mod_exp_engine_if #(parameter int DW = dh_pkg::DW_DEF);
  logic          start;
  logic [DW-1:0] base;
  logic [DW-1:0] exponent;
  logic [DW-1:0] p;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic          err;

  modport master (
    output start, base, exponent, p,
    input  busy, done, result, err
  );

  modport slave (
    input  start, base, exponent, p,
    output busy, done, result, err
  );
endinterface

// File: rtl/mod_reduce.sv
// Restoring shift-subtract reducer: remainder = dividend mod divisor.
// done rises exactly 2*DW cycles after start; remainder is valid while done is high.
module mod_reduce
  import dh_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            done,
  output logic [DW-1:0]   remainder
);

  localparam int CW = $clog2(2 * DW);

  logic            active;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   rem;
  logic [2*DW-1:0] shreg;
  logic [DW-1:0]   div_q;

  // Bring down one dividend bit and subtract the divisor when it fits.
  // The partial remainder stays below the divisor, so the DW+1 bit
  // intermediate cannot overflow and the result fits back into DW bits.
  function automatic logic [DW-1:0] step(input logic [DW-1:0] r,
                                         input logic          b,
                                         input logic [DW-1:0] d);
    logic [DW:0] t;
    t = {r, b};
    if (t >= {1'b0, d}) t = t - {1'b0, d};
    return t[DW-1:0];
  endfunction

  // The first quotient bit is produced on the start edge itself, so the
  // last of the 2*DW bits lands in the cycle done is raised.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst) begin
      active <= 1'b0;
      cnt    <= '0;
      rem    <= '0;
      shreg  <= '0;
      div_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= CW'(red_cycles(DW) - 1);
      rem    <= step('0, dividend[2*DW-1], divisor);
      shreg  <= dividend << 1;
      div_q  <= divisor;
    end else if (active) begin
      if (cnt == '0) begin
        active <= 1'b0;
      end else begin
        cnt   <= cnt - 1'b1;
        rem   <= step(rem, shreg[2*DW-1], div_q);
        shreg <= shreg << 1;
      end
    end
  end

  assign done      = active && (cnt == '0);
  assign remainder = rem;

endmodule

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiation:
// result = base^exponent mod p, using one shared multiplier and one reducer.
module mod_exp_engine
  import dh_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  mod_exp_engine_if.slave  bus
);

  state_t state, next_state;

  logic [DW-1:0]   acc_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   e_q;
  logic [DW-1:0]   p_q;
  logic [DW-1:0]   result_q;
  logic            err_q;

  logic [DW-1:0]   mul_a;
  logic [2*DW-1:0] prod;
  logic            red_start;
  logic [2*DW-1:0] red_dividend;
  logic            red_done;
  logic [DW-1:0]   red_rem;

  // Single multiplier: acc*b in MUL_ACC, b*b otherwise; full 2*DW product.
  assign mul_a = (state == MUL_ACC) ? acc_q : b_q;
  assign prod  = {{DW{1'b0}}, mul_a} * {{DW{1'b0}}, b_q};

  // LOAD reduces the raw (possibly >= p) base; all later work reduces products.
  assign red_dividend = (state == LOAD) ? {{DW{1'b0}}, b_q} : prod;

  mod_reduce #(.DW(DW)) u_reduce (
    .clk       (clk),
    .rst       (rst),
    .start     (red_start),
    .dividend  (red_dividend),
    .divisor   (p_q),
    .done      (red_done),
    .remainder (red_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and reducer start decode.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    next_state = state;
    red_start  = 1'b0;
    unique case (state)
      IDLE:     if (bus.start) next_state = LOAD;
      LOAD: begin
        if (p_q == '0) begin
          next_state = FINISH;
        end else begin
          next_state = RED_BASE;
          red_start  = 1'b1;
        end
      end
      RED_BASE: if (red_done) next_state = CHK_BIT;
      CHK_BIT: begin
        if (e_q == '0)  next_state = FINISH;
        else if (e_q[0]) next_state = MUL_ACC;
        else             next_state = SQR;
      end
      MUL_ACC: begin
        red_start  = 1'b1;
        next_state = RED_ACC;
      end
      RED_ACC:  if (red_done) next_state = SQR;
      SQR: begin
        // The final squaring is never needed once the exponent is exhausted.
        if ((e_q >> 1) == '0) begin
          next_state = FINISH;
        end else begin
          red_start  = 1'b1;
          next_state = RED_SQR;
        end
      end
      RED_SQR:  if (red_done) next_state = CHK_BIT;
      FINISH:   next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Operand capture, accumulator/base/exponent updates and result latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      e_q      <= '0;
      p_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            b_q   <= bus.base;
            e_q   <= bus.exponent;
            p_q   <= bus.p;
            err_q <= 1'b0;
          end
        end
        LOAD: begin
          // 1 mod p: zero when p == 1.
          acc_q <= (p_q == DW'(1)) ? '0 : DW'(1);
          if (p_q == '0) begin
            err_q    <= 1'b1;
            result_q <= '0;
          end
        end
        RED_BASE: if (red_done) b_q <= red_rem;
        CHK_BIT:  if (e_q == '0) result_q <= acc_q;
        RED_ACC:  if (red_done) acc_q <= red_rem;
        SQR: begin
          e_q <= e_q >> 1;
          if ((e_q >> 1) == '0) result_q <= acc_q;
        end
        RED_SQR:  if (red_done) b_q <= red_rem;
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == FINISH);
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Self-checking bench for mod_exp_engine: directed cases, randomized operands,
// a plain-arithmetic exponentiation model and one compare process on done.
module tb_mod_exp_engine;

  localparam int DW    = 32;
  localparam int BOUND = 3 + (2 * DW + 2) * (1 + 2 * DW);
  localparam int LIMIT = BOUND + 50;

  typedef struct {
    logic [DW-1:0] res;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mod_exp_engine_if #(.DW(DW)) bus ();

  mod_exp_engine #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: base^exponent mod m by repeated squaring on 64-bit integers.
  function automatic logic [DW-1:0] model(input logic [DW-1:0] b, input logic [DW-1:0] e,
                                          input logic [DW-1:0] m);
    logic [63:0] r, x, mm;
    logic [DW-1:0] k;
    if (m == '0) return '0;
    mm = {32'd0, m};
    r  = 64'd1 % mm;
    x  = {32'd0, b} % mm;
    k  = e;
    while (k != '0) begin
      if (k[0]) r = (r * x) % mm;
      x = (x * x) % mm;
      k = k >> 1;
    end
    return r[DW-1:0];
  endfunction

  // Compare process: every done pulse must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      check("done_pending", DW'(exp_q.size() != 0), DW'(1));
      check("done_single_cycle", DW'(prev_done), DW'(0));
      check("busy_at_done", DW'(bus.busy), DW'(1));
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result, e.res);
        check("err", DW'(bus.err), DW'(e.err));
      end
    end
    prev_done = rst && bus.done;
  end

  task automatic start_op(input logic [DW-1:0] b, input logic [DW-1:0] e,
                          input logic [DW-1:0] m, input bit expect_it);
    exp_t x;
    @(negedge clk);
    bus.base = b; bus.exponent = e; bus.p = m; bus.start = 1'b1;
    if (expect_it) begin
      x.res = model(b, e, m);
      x.err = (m == '0);
      exp_q.push_back(x);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", DW'(bus.busy), DW'(1));
    if (expect_it) check("err_cleared_on_start", DW'(bus.err), DW'(0));
    // Operands must already be captured; scramble the inputs.
    bus.base = $urandom; bus.exponent = $urandom; bus.p = $urandom;
  endtask

  task automatic wait_done(output logic [DW-1:0] res, output int lat);
    bit got;
    got = 1'b0;
    lat = 1;
    while (!got && lat < LIMIT) begin
      if (bus.done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check("done_seen", DW'(got), DW'(1));
    res = bus.result;
    @(negedge clk);
    check("busy_after_done", DW'(bus.busy), DW'(0));
  endtask

  task automatic run_op(input logic [DW-1:0] b, input logic [DW-1:0] e,
                        input logic [DW-1:0] m, output logic [DW-1:0] res);
    int lat;
    start_op(b, e, m, 1'b1);
    wait_done(res, lat);
    check("latency_bound", DW'(lat <= BOUND), DW'(1));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] r, ra, rb, s1, s2, bb, ee, pp;
    int lat, bits;

    bus.start = 1'b0; bus.base = '0; bus.exponent = '0; bus.p = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", DW'(bus.busy), DW'(0));
    check("reset_done", DW'(bus.done), DW'(0));
    check("reset_err", DW'(bus.err), DW'(0));
    check("reset_result", bus.result, '0);
    rst = 1'b1;

    run_op(32'd5, 32'd3, 32'd23, r);     check("lit_5_3_23", r, 32'd10);
    repeat (3) @(negedge clk);
    check("result_held", bus.result, 32'd10);
    run_op(32'd2, 32'd10, 32'd1000, r);  check("lit_2_10_1000", r, 32'd24);
    run_op(32'd1027, 32'd1, 32'd1000, r); check("lit_base_ge_p", r, 32'd27);
    run_op(32'd9, 32'd0, 32'd23, r);     check("lit_exp0", r, 32'd1);
    run_op(32'd7, 32'd5, 32'd1, r);      check("lit_p1", r, 32'd0);
    run_op(32'd7, 32'd0, 32'd1, r);      check("lit_exp0_p1", r, 32'd0);
    run_op(32'd7, 32'd5, 32'd0, r);      check("lit_p0", r, 32'd0);
    run_op(32'd3, 32'd4, 32'd100, r);    check("lit_after_err", r, 32'd81);

    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFB, r);

    // start while busy is ignored; the first request's result is delivered.
    start_op(32'd2, 32'd10, 32'd1000, 1'b1);
    repeat (20) @(negedge clk);
    bus.base = 32'd3; bus.exponent = 32'd7; bus.p = 32'd77; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(r, lat);
    check("ignored_restart", r, 32'd24);
    repeat (5) @(negedge clk);

    // Reset in the middle of an operation.
    start_op(32'd5, 32'd15, 32'd23, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_busy", DW'(bus.busy), DW'(0));
    check("midreset_done", DW'(bus.done), DW'(0));
    check("midreset_result", bus.result, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("postreset_idle", DW'(bus.busy), DW'(0));

    // Diffie-Hellman round trip.
    run_op(32'd5, 32'd6, 32'd23, ra);    check("dh_A", ra, 32'd8);
    run_op(32'd5, 32'd15, 32'd23, rb);   check("dh_B", rb, 32'd19);
    run_op(rb, 32'd6, 32'd23, s1);       check("dh_shared_1", s1, 32'd2);
    run_op(ra, 32'd15, 32'd23, s2);      check("dh_shared_2", s2, 32'd2);

    // Randomized operands; short exponents keep the run bounded.
    for (int i = 0; i < 20; i++) begin
      bits = $urandom_range(1, 12);
      bb = $urandom;
      ee = $urandom & ((32'd1 << bits) - 32'd1);
      pp = (i % 4 == 0) ? DW'($urandom_range(1, 50)) : DW'($urandom);
      if (i == 7) pp = '0;
      run_op(bb, ee, pp, r);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", DW'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
